if_fetch_icache: RTL
====================

Name: if_fetch_icache

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current fetch PC and its predicted-jump tag, and looks the word up in a direct-mapped, word-granular instruction cache.
- On a miss, assembles the 32-bit instruction from four byte reads over the shared 8-bit memory-controller port.
- Delivers pc/inst/jmp as registered outputs to the IF/ID register, and raises a stall request so the PC register holds while a fetch is outstanding.

Parameters:
- INDEX_W, 6, cache index bits. Lines = 2**INDEX_W. Index = pc_i[INDEX_W+1:2], tag = pc_i[31:INDEX_W+2].

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- pc_i  input  32  fetch PC from the PC register. Word-aligned; bits [1:0] ignored.
- jmp_i  input  1  predicted-jump tag accompanying pc_i
- flush_i  input  1  EX branch redirect; kill in-flight fetch and output
- stall_i  input  1  downstream (IF/ID) not accepting; freeze outputs
- stall_req_o  output  1  combinational; high while this stage cannot deliver pc_i
- mem_req_o  output  1  byte read request to the memory controller
- mem_addr_o  output  32  byte address of the request
- mem_ack_i  input  1  read done this cycle; mem_data_i valid for mem_addr_o
- mem_data_i  input  8  returned byte
- pc_o  output  32  registered PC of the delivered instruction
- inst_o  output  32  registered instruction
- jmp_o  output  1  registered jump tag
- valid_o  output  1  registered; pc_o/inst_o/jmp_o meaningful

Behaviour:
- Reset:
  - All cache valid bits cleared. FSM goes to IDLE and the byte counter to 0.
  - pc_o, inst_o = 0; jmp_o, valid_o, mem_req_o = 0; mem_addr_o = 0.
  - Reset mid-fetch discards all partial bytes.
- Cache: one 32-bit word per line, plus tag and valid bit. hit = valid[idx] && tag[idx] == pc_i tag. The array may be register- or LUT-based, with combinational read.
- FSM states: IDLE, FETCH.
- IDLE:
  - flush_i → valid_o <= 0. No lookup action this cycle.
  - Else if stall_i → outputs held. No miss is started.
  - Else if hit → next edge: pc_o <= pc_i, inst_o <= line, jmp_o <= jmp_i, valid_o <= 1. stall_req_o = 0.
  - Else (miss) → stall_req_o = 1. valid_o <= 0 (unless stall_i). Latch fetch_pc <= {pc_i[31:2], 2'b00} and cnt <= 0. Go to FETCH.
- FETCH:
  - mem_req_o = 1 and mem_addr_o = fetch_pc + cnt, driven from registers. stall_req_o = 1, except in the completion cycle (below).
  - Each cycle with mem_ack_i: buf[8*cnt+7 : 8*cnt] <= mem_data_i (little-endian), then cnt <= cnt + 1.
  - Ack with cnt == 3 (completion):
    - Write the line (tag, word, valid) and go to IDLE. mem_req_o drops next cycle.
    - If !stall_i && !flush_i, in the same edge: pc_o <= fetch_pc, inst_o <= assembled word, jmp_o <= jmp_i, valid_o <= 1. stall_req_o = 0 in that cycle, so the PC register advances with zero bubble.
    - If stall_i, outputs hold and stall_req_o stays 1. The later IDLE hit delivers the word once stall_i drops.
  - No ack: hold state. There is no timeout; ack gaps of any length are legal.
  - Cycles without ack → valid_o <= 0 unless stall_i.
  - flush_i in FETCH:
    - Abort to IDLE, cnt <= 0, valid_o <= 0. mem_req_o low next cycle.
    - A byte acked in the flush cycle is discarded, except that an ack with cnt == 3 still writes the cache line (data is correct). No output is produced.
- Simultaneous flush_i and stall_i: flush wins (valid_o <= 0).
- pc_i is stable while stall_req_o = 1 except on flush. The EX stage guarantees flush_i accompanies every redirect.
- Address arithmetic: 32-bit. fetch_pc + cnt never carries across the word, since fetch_pc[1:0] = 0.

Test Plan:
- Reset, then cold miss: pc_i = 0x0000_0000, ack every cycle with bytes 0x13, 0x05, 0x00, 0x00 → mem_addr_o 0, 1, 2, 3 on consecutive cycles. After the 4th ack edge: inst_o = 0x0000_0513, pc_o = 0, valid_o = 1. stall_req_o low in the 4th-ack cycle.
- Hit: re-present pc_i = 0x0 after a miss → no mem_req_o. Next edge: valid_o = 1, inst_o = 0x0000_0513, stall_req_o stays 0.
- Flush mid-fetch: miss at 0x10, two bytes acked, then flush_i → valid_o = 0, mem_req_o = 0 next cycle. A new miss at 0x20 then restarts at mem_addr_o = 0x20.
- Downstream stall at completion: stall_i high during the 4th ack → outputs unchanged, stall_req_o = 1. When stall_i drops, the next edge delivers via hit with no memory traffic.
- Conflict eviction (INDEX_W = 6): fetch 0x000 then 0x100 (same index 0, different tag) → both miss. Re-fetching 0x000 misses again with 4 byte reads.
- Ack gaps and reset: 3-cycle gaps between acks assemble the correct word. Asserting rst after 2 bytes → mem_req_o = 0, valid_o = 0, and a subsequent fetch of the same PC misses.

Source files
------------

// File: rtl/if_fetch_icache.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_icache
// Purpose  : Instruction-fetch stage with a direct-mapped, word-granular
//            instruction cache. A miss builds the 32-bit word from four
//            little-endian byte reads on the shared 8-bit memory port. The
//            stage delivers registered pc/inst/jmp to IF/ID and asks the PC
//            register to hold while a fetch is outstanding.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            pc_i, jmp_i          - fetch PC and its predicted-jump tag
//            flush_i              - branch redirect, kills fetch and output
//            stall_i              - IF/ID not accepting, outputs freeze
//            stall_req_o          - combinational hold request to PC register
//            mem_req_o/addr_o     - byte read request and byte address
//            mem_ack_i/data_i     - read completion and returned byte
//            pc_o/inst_o/jmp_o    - registered delivered instruction
//            valid_o              - registered output-valid flag
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_icache #(
  parameter int INDEX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        jmp_i,
  input  logic        flush_i,
  input  logic        stall_i,
  output logic        stall_req_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        jmp_o,
  output logic        valid_o
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 30 - INDEX_W;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t state, state_nx;
  logic [1:0]  cnt, cnt_nx;
  logic [29:0] fetch_word;   // fetch_pc[31:2]; low two bits are always zero
  logic [23:0] byte_buf;     // bytes 0..2; byte 3 is taken straight off the bus

  logic [LINES-1:0] line_valid;
  logic [TAG_W-1:0] line_tag  [LINES];
  logic [31:0]      line_data [LINES];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic               done;
  logic [31:0]        fill_word;
  logic [INDEX_W-1:0] fill_idx;
  logic [TAG_W-1:0]   fill_tag;

  logic start_miss;
  logic deliver_hit;
  logic deliver_fill;
  logic clear_valid;

  assign idx       = pc_i[INDEX_W+1:2];
  assign tag       = pc_i[31:INDEX_W+2];
  assign hit       = line_valid[idx] && (line_tag[idx] == tag);
  assign done      = (state == FETCH) && mem_ack_i && (cnt == 2'd3);
  assign fill_word = {mem_data_i, byte_buf};
  assign fill_idx  = fetch_word[INDEX_W-1:0];
  assign fill_tag  = fetch_word[29:INDEX_W];

  // The request comes straight from state registers; after reset both the
  // latched word address and the counter are zero, so mem_addr_o is zero.
  assign mem_req_o  = (state == FETCH);
  assign mem_addr_o = {fetch_word, cnt};

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    stall_req_o  = 1'b0;
    start_miss   = 1'b0;
    deliver_hit  = 1'b0;
    deliver_fill = 1'b0;
    clear_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (flush_i) begin
          clear_valid = 1'b1;
        end else if (stall_i) begin
          // Frozen: a miss waits until downstream frees up.
          stall_req_o = !hit;
        end else if (hit) begin
          deliver_hit = 1'b1;
        end else begin
          stall_req_o = 1'b1;
          clear_valid = 1'b1;
          start_miss  = 1'b1;
          cnt_nx      = 2'd0;
          state_nx    = FETCH;
        end
      end
      FETCH: begin
        stall_req_o = 1'b1;
        if (flush_i) begin
          state_nx    = IDLE;
          cnt_nx      = 2'd0;
          clear_valid = 1'b1;
        end else if (mem_ack_i) begin
          cnt_nx = cnt + 2'd1;
          if (cnt == 2'd3) begin
            state_nx = IDLE;
            if (!stall_i) begin
              // Deliver on the completing edge so the PC advances bubble-free.
              deliver_fill = 1'b1;
              stall_req_o  = 1'b0;
            end
          end else if (!stall_i) begin
            clear_valid = 1'b1;
          end
        end else if (!stall_i) begin
          clear_valid = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      fetch_word <= 30'd0;
      byte_buf   <= 24'd0;
      pc_o       <= 32'd0;
      inst_o     <= 32'd0;
      jmp_o      <= 1'b0;
      valid_o    <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (start_miss) begin
        fetch_word <= pc_i[31:2];
      end
      // Bytes acked in a flush cycle are dropped.
      if ((state == FETCH) && mem_ack_i && !flush_i) begin
        case (cnt)
          2'd0:    byte_buf[7:0]   <= mem_data_i;
          2'd1:    byte_buf[15:8]  <= mem_data_i;
          2'd2:    byte_buf[23:16] <= mem_data_i;
          default: byte_buf        <= byte_buf;
        endcase
      end
      if (deliver_hit) begin
        pc_o    <= pc_i;
        inst_o  <= line_data[idx];
        jmp_o   <= jmp_i;
        valid_o <= 1'b1;
      end else if (deliver_fill) begin
        pc_o    <= {fetch_word, 2'b00};
        inst_o  <= fill_word;
        jmp_o   <= jmp_i;
        valid_o <= 1'b1;
      end else if (clear_valid) begin
        valid_o <= 1'b0;
      end
    end
  end

  // Valid bits are reset; a completed fill writes the line even when flushed
  // or stalled, since the assembled data is correct either way.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_valid <= '0;
    end else if (done) begin
      line_valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (done) begin
      line_tag[fill_idx]  <= fill_tag;
      line_data[fill_idx] <= fill_word;
    end
  end

endmodule
`default_nettype wire
